// File: rtl/ucc_pkg.sv
// Shared types for the universal-counter command sequencer.
package ucc_pkg;

  localparam int unsigned UCC_WIDTH  = 8;
  localparam int unsigned UCC_STEP_W = 8;

  typedef enum logic [1:0] {
    CM_HOLD = 2'd0,
    CM_UP   = 2'd1,
    CM_DOWN = 2'd2,
    CM_LOAD = 2'd3
  } ctr_mode_e;

  typedef enum logic [1:0] {
    OP_NOP  = 2'd0,
    OP_UP   = 2'd1,
    OP_DOWN = 2'd2,
    OP_LOAD = 2'd3
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_UP,
    ST_DOWN,
    ST_DONE
  } seq_state_e;

endpackage

// File: rtl/ucc_cmd_sequencer_if.sv
// Command valid/ready channel into the sequencer.
interface ucc_cmd_sequencer_if #(
  parameter int unsigned WIDTH = 8
);
  import ucc_pkg::*;

  logic             cmd_valid;
  logic             cmd_ready;
  cmd_op_e          cmd_op;
  logic [WIDTH-1:0] cmd_data;

  modport master (output cmd_valid, cmd_op, cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, cmd_op, cmd_data, output cmd_ready);

endinterface

// File: rtl/ucc_step_counter.sv
// Remaining-step down-counter for UP commands; flags the final step.
module ucc_step_counter #(
  parameter int unsigned STEP_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic [STEP_W-1:0] load_val_i,
  input  logic              dec_i,
  output logic              is_one_o
);

  logic [STEP_W-1:0] cnt_q, cnt_d;

  // Saturate at zero so a stray dec never wraps into a huge count.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - STEP_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign is_one_o = (cnt_q == STEP_W'(1));

endmodule

// File: rtl/ucc_cmd_sequencer.sv
// Turns LOAD / UP-by-N / DOWN-to-zero / NOP commands into cycle-by-cycle counter controls.
module ucc_cmd_sequencer
  import ucc_pkg::*;
#(
  parameter int unsigned WIDTH  = UCC_WIDTH,
  parameter int unsigned STEP_W = UCC_STEP_W
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  ucc_cmd_sequencer_if.slave cmd_if,
  input  logic               abort_i,
  output ctr_mode_e          ctr_mode_o,
  output logic [WIDTH-1:0]   ctr_pin_o,
  output logic               ctr_cin_o,
  input  logic [WIDTH-1:0]   ctr_fout_i,
  input  logic               ctr_cout_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [WIDTH-1:0]   res_data_o,
  output logic               ovf_o,
  output logic               aborted_o
);

  seq_state_e       state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             ovf_q, ovf_d;
  logic             aborted_q, aborted_d;
  logic             step_load, step_dec, step_is_one;

  ucc_step_counter #(.STEP_W(STEP_W)) u_step (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (step_load),
    .load_val_i (cmd_if.cmd_data[STEP_W-1:0]),
    .dec_i      (step_dec),
    .is_one_o   (step_is_one)
  );

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    res_d      = res_q;
    ovf_d      = ovf_q;
    aborted_d  = aborted_q;
    step_load  = 1'b0;
    step_dec   = 1'b0;
    ctr_mode_o = CM_HOLD;
    ctr_pin_o  = '0;
    ctr_cin_o  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_if.cmd_valid) begin
          data_d    = cmd_if.cmd_data;
          ovf_d     = 1'b0;
          aborted_d = 1'b0;
          unique case (cmd_if.cmd_op)
            OP_NOP:  state_d = ST_DONE;
            OP_LOAD: state_d = ST_LOAD;
            OP_UP: begin
              step_load = 1'b1;
              state_d   = (cmd_if.cmd_data[STEP_W-1:0] == '0) ? ST_DONE : ST_UP;
            end
            OP_DOWN: state_d = (ctr_fout_i == '0) ? ST_DONE : ST_DOWN;
            default: state_d = ST_IDLE;
          endcase
        end
      end
      ST_LOAD: begin
        ctr_mode_o = CM_LOAD;
        ctr_pin_o  = data_q;
        state_d    = ST_DONE;
      end
      // An abort cycle issues no step; the counter keeps its value.
      ST_UP: begin
        if (abort_i) begin
          aborted_d = 1'b1;
          state_d   = ST_DONE;
        end else begin
          ctr_mode_o = CM_UP;
          ctr_cin_o  = 1'b1;
          step_dec   = 1'b1;
          if (ctr_cout_i) ovf_d = 1'b1;
          if (step_is_one) state_d = ST_DONE;
        end
      end
      ST_DOWN: begin
        if (abort_i) begin
          aborted_d = 1'b1;
          state_d   = ST_DONE;
        end else if (ctr_fout_i == '0) begin
          state_d = ST_DONE;
        end else begin
          ctr_mode_o = CM_DOWN;
          if (ctr_fout_i == WIDTH'(1)) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        res_d   = ctr_fout_i;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      data_q    <= '0;
      res_q     <= '0;
      ovf_q     <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      res_q     <= res_d;
      ovf_q     <= ovf_d;
      aborted_q <= aborted_d;
    end
  end

  assign cmd_if.cmd_ready = (state_q == ST_IDLE);
  assign busy_o           = (state_q != ST_IDLE);
  assign done_o           = (state_q == ST_DONE);
  // The result is live during the done pulse and then held.
  assign res_data_o       = (state_q == ST_DONE) ? ctr_fout_i : res_q;
  assign ovf_o            = ovf_q;
  assign aborted_o        = aborted_q;

endmodule
